// File: rtl/wb_trace_pkg.sv
// rtl/wb_trace_pkg.sv - shared record type, constants and sizing helper for the writeback trace serializer
package wb_trace_pkg;

  localparam int         WB_DATA_W  = 32;
  localparam logic [3:0] WB_WEN_ALL = 4'hF;

  // One retired register write at the default data width, packed as {pc, rd, wdata}
  typedef struct packed {
    logic [WB_DATA_W-1:0] pc;
    logic [4:0]           rd;
    logic [WB_DATA_W-1:0] wdata;
  } wb_rec_t;

  // Address bits needed to index a power-of-two buffer of 'depth' entries
  function automatic int clog2_depth(input int depth);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// rtl/wb_trace_fifo.sv - dual-write, single-read circular buffer holding flattened trace records
module wb_trace_fifo
  import wb_trace_pkg::*;
#(
  parameter  int DEPTH = 8,
  parameter  int REC_W = 69,
  localparam int AW    = clog2_depth(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push0,
  input  logic [REC_W-1:0] data0,
  input  logic             push1,
  input  logic [REC_W-1:0] data1,
  input  logic             pop,
  output logic [AW:0]      count,
  output logic [REC_W-1:0] head
);

  logic [REC_W-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [AW:0]      slot1_ptr;

  // The second write lands directly behind the first one when both are present
  assign slot1_ptr = wptr + (AW+1)'(push0);
  assign count     = wptr - rptr;
  assign head      = mem[rptr[AW-1:0]];

  // Storage array; contents need no reset since the pointers gate every read
  always_ff @(posedge clk) begin
    if (push0) mem[wptr[AW-1:0]] <= data0;
    if (push1) mem[slot1_ptr[AW-1:0]] <= data1;
  end

  // Pointers carry one extra wrap bit so a full buffer is distinguishable from empty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr + (AW+1)'(push0) + (AW+1)'(push1);
      if (pop) rptr <= rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/wb_trace_serializer.sv
// rtl/wb_trace_serializer.sv - serializes dual-issue writeback into the debug_wb trace; WB_TRACE_COUNT_EN adds trace_count
module wb_trace_serializer
  import wb_trace_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb0_en,
  input  logic [4:0]        wb0_rd,
  input  logic [DATA_W-1:0] wb0_wdata,
  input  logic [DATA_W-1:0] wb0_pc,
  input  logic              wb1_en,
  input  logic [4:0]        wb1_rd,
  input  logic [DATA_W-1:0] wb1_wdata,
  input  logic [DATA_W-1:0] wb1_pc,
  output logic              in_stall,
  input  logic              out_ready,
  output logic [DATA_W-1:0] debug_wb_pc,
  output logic [3:0]        debug_wb_rf_wen,
  output logic [4:0]        debug_wb_rf_wnum,
  output logic [DATA_W-1:0] debug_wb_rf_wdata,
  output logic              overflow_err
`ifdef WB_TRACE_COUNT_EN
  ,
  output logic [31:0]       trace_count
`endif
);

  localparam int          AW        = clog2_depth(DEPTH);
  localparam int          REC_W     = 2 * DATA_W + 5;
  localparam logic [AW:0] STALL_LVL = (AW+1)'(DEPTH - 1);

  logic             q0;
  logic             q1;
  logic             any_q;
  logic [REC_W-1:0] rec0;
  logic [REC_W-1:0] rec1;
  logic             push_first;
  logic             push_second;
  logic [REC_W-1:0] first_rec;
  logic             pop;
  logic [AW:0]      count;
  logic [REC_W-1:0] head;
  logic             out_valid;
  logic [REC_W-1:0] out_rec;

  // r0 writes carry no architectural effect and are never traced
  assign q0    = wb0_en && (wb0_rd != 5'd0);
  assign q1    = wb1_en && (wb1_rd != 5'd0);
  assign any_q = q0 || q1;
  assign rec0  = {wb0_pc, wb0_rd, wb0_wdata};
  assign rec1  = {wb1_pc, wb1_rd, wb1_wdata};

  // Stall reserves room for a full dual-issue cycle; it looks only at stored occupancy
  assign in_stall = !reset && (count >= STALL_LVL);

  // A stalled cycle drops both slots so program order is never split across cycles
  assign push_first  = any_q && !in_stall;
  assign push_second = q0 && q1 && !in_stall;
  assign first_rec   = q0 ? rec0 : rec1;

  assign pop = (!out_valid || out_ready) && (count != '0);

  wb_trace_fifo #(
    .DEPTH (DEPTH),
    .REC_W (REC_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push0 (push_first),
    .data0 (first_rec),
    .push1 (push_second),
    .data1 (rec1),
    .pop   (pop),
    .count (count),
    .head  (head)
  );

  // Output record: refill from the FIFO head, otherwise clear once consumed, otherwise hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_rec   <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_rec   <= head;
    end else if (out_ready && out_valid) begin
      out_valid <= 1'b0;
      out_rec   <= '0;
    end
  end

  // Sticky flag for any write attempt made while upstream was told to hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_err <= 1'b0;
    end else if (any_q && in_stall) begin
      overflow_err <= 1'b1;
    end
  end

`ifdef WB_TRACE_COUNT_EN
  // Counts records actually handed to the consumer; wraps naturally at 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trace_count <= '0;
    end else if (out_valid && out_ready) begin
      trace_count <= trace_count + 32'd1;
    end
  end
`endif

  assign debug_wb_pc       = out_rec[REC_W-1 -: DATA_W];
  assign debug_wb_rf_wnum  = out_rec[DATA_W +: 5];
  assign debug_wb_rf_wdata = out_rec[DATA_W-1:0];
  assign debug_wb_rf_wen   = out_valid ? WB_WEN_ALL : 4'h0;

endmodule

// File: tb/tb_wb_trace_serializer.sv
// tb/tb_wb_trace_serializer.sv - self-checking bench for wb_trace_serializer with a queue-based reference model
module tb_wb_trace_serializer;
  import wb_trace_pkg::*;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              wb0_en, wb1_en;
  logic [4:0]        wb0_rd, wb1_rd;
  logic [DATA_W-1:0] wb0_wdata, wb0_pc, wb1_wdata, wb1_pc;
  logic              in_stall;
  logic              out_ready;
  logic [DATA_W-1:0] debug_wb_pc;
  logic [3:0]        debug_wb_rf_wen;
  logic [4:0]        debug_wb_rf_wnum;
  logic [DATA_W-1:0] debug_wb_rf_wdata;
  logic              overflow_err;
`ifdef WB_TRACE_COUNT_EN
  logic [31:0]       trace_count;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: pending records, the visible record, sticky error, consumed count
  wb_rec_t     mq[$];
  bit          m_valid;
  wb_rec_t     m_out;
  bit          m_ovf;
  logic [31:0] m_count;

  wb_trace_serializer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .wb0_en            (wb0_en),
    .wb0_rd            (wb0_rd),
    .wb0_wdata         (wb0_wdata),
    .wb0_pc            (wb0_pc),
    .wb1_en            (wb1_en),
    .wb1_rd            (wb1_rd),
    .wb1_wdata         (wb1_wdata),
    .wb1_pc            (wb1_pc),
    .in_stall          (in_stall),
    .out_ready         (out_ready),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
    .overflow_err      (overflow_err)
`ifdef WB_TRACE_COUNT_EN
    ,
    .trace_count       (trace_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_valid = 1'b0;
    m_out   = '0;
    m_ovf   = 1'b0;
    m_count = '0;
  endtask

  function automatic bit model_stall();
    return (DEPTH - mq.size()) < 2;
  endfunction

  task automatic drive(input bit e0, input logic [4:0] r0, input logic [31:0] d0, input logic [31:0] p0,
                       input bit e1, input logic [4:0] r1, input logic [31:0] d1, input logic [31:0] p1);
    wb0_en = e0; wb0_rd = r0; wb0_wdata = d0; wb0_pc = p0;
    wb1_en = e1; wb1_rd = r1; wb1_wdata = d1; wb1_pc = p1;
  endtask

  task automatic idle();
    drive(0, 5'd0, 32'd0, 32'd0, 0, 5'd0, 32'd0, 32'd0);
  endtask

  task automatic compare_all();
    check("in_stall", in_stall, model_stall());
    check("wen", debug_wb_rf_wen, m_valid ? 4'hF : 4'h0);
    check("pc", debug_wb_pc, m_out.pc);
    check("wnum", debug_wb_rf_wnum, m_out.rd);
    check("wdata", debug_wb_rf_wdata, m_out.wdata);
    check("overflow_err", overflow_err, m_ovf);
`ifdef WB_TRACE_COUNT_EN
    check("trace_count", trace_count, m_count);
`endif
  endtask

  // Apply one clock edge to the model using the inputs currently driven, then compare
  task automatic tick();
    bit t0, t1, stall_now, popm;
    stall_now = model_stall();
    t0 = wb0_en && (wb0_rd != 0);
    t1 = wb1_en && (wb1_rd != 0);
    popm = (!m_valid || out_ready) && (mq.size() > 0);
    if (m_valid && out_ready) m_count++;
    if (popm) begin
      m_out = mq.pop_front();
      m_valid = 1'b1;
    end else if (out_ready && m_valid) begin
      m_valid = 1'b0;
      m_out = '0;
    end
    if ((t0 || t1) && stall_now) begin
      m_ovf = 1'b1;
    end else begin
      if (t0) mq.push_back('{pc: wb0_pc, rd: wb0_rd, wdata: wb0_wdata});
      if (t1) mq.push_back('{pc: wb1_pc, rd: wb1_rd, wdata: wb1_wdata});
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    out_ready = 1'b1;
    idle();
    model_clear();
    #1;
    check("reset_wen", debug_wb_rf_wen, 4'h0);
    check("reset_stall", in_stall, 1'b0);
    check("reset_ovf", overflow_err, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Dual push: slot 0 then slot 1, first record visible two edges after the push
    drive(1, 5'd2, 32'h11, 32'hBFC00000, 1, 5'd3, 32'h22, 32'hBFC00004);
    tick();
    check("dual_latency", debug_wb_rf_wen, 4'h0);
    idle();
    tick();
    check("dual_first_pc", debug_wb_pc, 32'hBFC00000);
    check("dual_first_rd", debug_wb_rf_wnum, 5'd2);
    check("dual_first_data", debug_wb_rf_wdata, 32'h11);
    tick();
    check("dual_second_pc", debug_wb_pc, 32'hBFC00004);
    check("dual_second_rd", debug_wb_rf_wnum, 5'd3);
    check("dual_second_wen", debug_wb_rf_wen, 4'hF);
    tick();
    check("dual_done", debug_wb_rf_wen, 4'h0);

    // r0 filter: only the slot 1 write is traced
    drive(1, 5'd0, 32'hDEAD, 32'h100, 1, 5'd5, 32'h55, 32'h104);
    tick();
    idle();
    tick();
    check("r0_rd", debug_wb_rf_wnum, 5'd5);
    check("r0_pc", debug_wb_pc, 32'h104);
    tick();
    check("r0_nothing_more", debug_wb_rf_wen, 4'h0);

    // Backpressure: 4 dual pushes with the consumer stalled, then a forced fifth
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'd1 + 5'(2*i), 32'(2*i), 32'h1000 + 32'(8*i),
            1, 5'd2 + 5'(2*i), 32'(2*i+1), 32'h1004 + 32'(8*i));
      tick();
    end
    check("bp_stall", in_stall, 1'b1);
    check("bp_ovf_clear", overflow_err, 1'b0);
    drive(1, 5'd20, 32'hBAD0, 32'hBAD0, 1, 5'd21, 32'hBAD1, 32'hBAD1);
    tick();
    check("bp_ovf_set", overflow_err, 1'b1);
    idle();
    check("bp_head_pc", debug_wb_pc, 32'h1000);
    out_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      tick();
      check("bp_drain_pc", debug_wb_pc, 32'h1000 + 32'(4*i));
    end
    tick();
    check("bp_drained", debug_wb_rf_wen, 4'h0);
    check("bp_ovf_sticky", overflow_err, 1'b1);

    // Hold: stalled consumer keeps the record; one ready cycle advances exactly one
    do_reset();
    check("hold_ovf_cleared", overflow_err, 1'b0);
    out_ready = 1'b0;
    drive(1, 5'd7, 32'h70, 32'h2000, 1, 5'd8, 32'h80, 32'h2004);
    tick();
    drive(1, 5'd9, 32'h90, 32'h2008, 0, 5'd0, 32'd0, 32'd0);
    tick();
    idle();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_pc", debug_wb_pc, 32'h2000);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hold_advance_pc", debug_wb_pc, 32'h2004);
    tick();
    check("hold_after_pc", debug_wb_pc, 32'h2004);

    // Asynchronous reset between edges with records still queued
    reset = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    check("async_wen", debug_wb_rf_wen, 4'h0);
    check("async_pc", debug_wb_pc, 32'h0);
    check("async_stall", in_stall, 1'b0);
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_stale", debug_wb_rf_wen, 4'h0);
    end

    // Random traffic with an upstream that honours in_stall
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (model_stall()) begin
        idle();
      end else begin
        drive($urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)), $urandom, $urandom,
              $urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)), $urandom, $urandom);
      end
      tick();
    end
    idle();
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) tick();
    check("random_drained", debug_wb_rf_wen, 4'h0);
    check("random_no_ovf", overflow_err, 1'b0);

`ifdef WB_TRACE_COUNT_EN
    do_reset();
    check("count_reset", trace_count, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive(1, 5'd1 + 5'(i % 31), 32'(i), 32'h3000 + 32'(4*i), 0, 5'd0, 32'd0, 32'd0);
      tick();
    end
    idle();
    for (int i = 0; i < 3; i++) tick();
    check("count_100", trace_count, 32'd100);
    do_reset();
    #1;
    check("count_cleared", trace_count, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_trace_serializer.md
Name: wb_trace_serializer

Overview:
- Converts the dual-issue writeback ports (slot 0, slot 1) into the single-lane `debug_wb_*` trace stream used for golden-trace comparison.
- Emits one retired register write per cycle, in program order: slot 0 before slot 1.
- Buffers bursts in a small FIFO and back-pressures writeback via `in_stall`.
- Sits between the datapath writeback stage and the SoC debug port.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 4.
- DATA_W, 32, width of PC and write data.

Ports:
- clk  input  1  core clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- wb0_en  input  1  slot 0 register write valid.
- wb0_rd  input  5  slot 0 destination register.
- wb0_wdata  input  DATA_W  slot 0 write data.
- wb0_pc  input  DATA_W  slot 0 instruction PC.
- wb1_en, wb1_rd, wb1_wdata, wb1_pc  input  1/5/DATA_W/DATA_W  slot 1; same meanings as slot 0.
- in_stall  output  1  fewer than 2 free FIFO entries; upstream must hold writeback.
- out_ready  input  1  consumer accepts the current record; tie high for free-running trace.
- debug_wb_pc  output  DATA_W  PC of the current record.
- debug_wb_rf_wen  output  4  4'hF when a record is valid, else 4'h0.
- debug_wb_rf_wnum  output  5  destination register of the current record.
- debug_wb_rf_wdata  output  DATA_W  data of the current record.
- overflow_err  output  1  sticky: a push was attempted while `in_stall` was high.

Behaviour:
- Reset is asynchronous and active-high; it may arrive mid-operation.
  - All debug outputs go to 0, `overflow_err` to 0, and the FIFO empties.
  - `in_stall` = 0 while reset is asserted.
- Filtering:
  - A slot is pushed only if its `en` = 1 and `rd` != 0.
  - Writes to r0 are never traced.
- Push:
  - 0, 1 or 2 entries per cycle, at the rising edge.
  - If both slots qualify, slot 0 goes to `wptr` and slot 1 to `wptr+1`.
  - If only slot 1 qualifies, it goes to `wptr`.
  - Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. `count = wptr - rptr`.
- `in_stall` = (DEPTH - count) < 2.
  - Combinational from registered `count`; it does not depend on the current inputs.
  - If any slot qualifies while `in_stall` = 1: the whole cycle's pushes are dropped (neither slot written) and `overflow_err` is set until reset.
- Output register:
  - Holds one record; valid is indicated by `wen` = 4'hF.
  - Each edge: if (output invalid or `out_ready`) and count > 0, load the FIFO head and advance `rptr`.
  - Else if `out_ready` and output valid, clear the output: all fields become 0.
  - Else hold.
- Latency: an entry pushed at edge k appears on the outputs after edge k+1 (2-edge latency with an empty FIFO). No bypass.
- Simultaneous push and pop in one cycle: `count` += pushes − pop. Full throughput: steady 1 in/cycle never stalls.
- With `out_ready` held high, one record retires per cycle; the sustained rate is 1/cycle.

Optional Feature:
- Macro: WB_TRACE_COUNT_EN.
- When defined:
  - Adds output port `trace_count` (32 bits).
  - It increments by 1 on every edge where a valid output record is consumed (valid & `out_ready`).
  - Reset to 0; wraps at 2^32.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package `wb_trace_pkg`:
  - Typedef `wb_rec_t` (pc, rd, wdata).
  - Constant `WB_WEN_ALL` = 4'hF.
  - Function `clog2_depth`.
- Natural sub-module `wb_trace_fifo`:
  - Dual-write, single-read circular buffer.
  - Exposes count, head, push0/push1, pop.
- Top level holds the filtering, stall and output-register logic.

Test Plan:
- Reset mid-stream: 3 entries queued, assert reset asynchronously between edges → outputs 0 and `in_stall` = 0 immediately; no stale record after release.
- Dual push: one cycle with slot0 {pc=BFC00000, rd=2, data=11} and slot1 {pc=BFC00004, rd=3, data=22}, `out_ready` = 1 → records appear in order on consecutive cycles with `wen` = F, starting 2 edges after push.
- r0 filter: slot0 rd=0 en=1 and slot1 rd=5 en=1 → only the rd=5 record is emitted; slot0 never appears.
- Backpressure: `out_ready` = 0, push 2/cycle for 4 cycles (DEPTH=8) → `in_stall` rises once count ≥ 7; a forced 5th push sets `overflow_err`, the FIFO keeps 8 records and all 8 drain in order.
- Hold: `out_ready` = 0 with a valid output → outputs stable for 10 cycles; `out_ready` = 1 for one cycle → advances exactly one record.
- WB_TRACE_COUNT_EN: drain 100 records → `trace_count` = 100; reset → 0.
